// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// WORD_SIZE sets the PC, address and instruction width.
package fetch_pkg;

    localparam int WORD_SIZE = 32;
    localparam logic [WORD_SIZE-1:0] NOP_INSTR = '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [WORD_SIZE-1:0] pc;
        logic [WORD_SIZE-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding register for a fetched {pc, instr} pair.
// A write takes priority over a read, so a simultaneous read and write leaves the buffer full.
module fetch_skid_buf
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_i,
    input  logic         rd_i,
    input  logic         clr_i,
    input  fetch_entry_t wr_data_i,
    output fetch_entry_t rd_data_o,
    output logic         full_o
);

    logic         full_q;
    fetch_entry_t data_q;

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else if (wr_i) begin
            full_q <= 1'b1;
            data_q <= wr_data_i;
        end else if (rd_i) begin
            full_q <= 1'b0;
        end
    end

    assign rd_data_o = data_q;
    assign full_o    = full_q;

endmodule

// File: rtl/instr_fetch_stage.sv
// Fetch stage: one outstanding imem read per PC, result into the IF/ID register.
// Valid/ready: a request transfers on any edge where imem_req_valid && imem_req_ready; the address is held until then.
module instr_fetch_stage
    import fetch_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 halt,
    input  logic                 stall,
    input  logic                 flush,
    input  logic [WORD_SIZE-1:0] pc_in,
    output logic                 pc_hold,
    output logic                 imem_req_valid,
    input  logic                 imem_req_ready,
    output logic [WORD_SIZE-1:0] imem_addr,
    input  logic                 imem_resp_valid,
    input  logic [WORD_SIZE-1:0] imem_resp_data,
    output logic                 id_valid,
    output logic [WORD_SIZE-1:0] id_instr,
    output logic [WORD_SIZE-1:0] id_pc,
    output logic [WORD_SIZE-1:0] id_pc_plus4,
    output logic [31:0]          fetch_count,
    output fetch_state_t         dbg_state,
    output logic                 dbg_buf_full
);

    fetch_state_t         state_q, state_d;
    logic [WORD_SIZE-1:0] addr_q, addr_d;
    logic                 drop_q, drop_d;
    logic                 id_valid_q, id_valid_d;
    fetch_entry_t         id_entry_q, id_entry_d;
    logic [31:0]          count_q, count_d;

    logic         handshake;
    logic         resp_take;
    logic         deliver;
    fetch_entry_t resp_entry;
    logic         buf_wr, buf_rd, buf_clr, buf_full;
    fetch_entry_t buf_data;

    always_comb begin
        handshake  = (state_q == REQ) && imem_req_ready;
        resp_take  = imem_resp_valid && (state_q == WAIT);
        deliver    = resp_take && !drop_q && !flush;
        resp_entry = '{pc: addr_q, instr: imem_resp_data};
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE: begin
                if (!halt && !buf_full && !flush) begin
                    state_d = REQ;
                    addr_d  = pc_in;
                end
            end
            REQ:     if (imem_req_ready) state_d = WAIT;
            WAIT:    if (imem_resp_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A response that lands in the flush cycle is itself discarded, so nothing is left to drop.
    always_comb begin
        drop_d = drop_q;
        if (resp_take) drop_d = 1'b0;
        if (flush) drop_d = (state_q == REQ) || ((state_q == WAIT) && !imem_resp_valid);
    end

    always_comb begin
        id_valid_d = id_valid_q;
        id_entry_d = id_entry_q;
        buf_wr     = 1'b0;
        buf_rd     = 1'b0;
        buf_clr    = 1'b0;
        count_d    = count_q;
        if (id_valid_q && !stall && !flush) count_d = count_q + 32'd1;
        if (flush) begin
            id_valid_d       = 1'b0;
            id_entry_d.instr = NOP_INSTR;
            buf_clr          = 1'b1;
        end else if (!stall && buf_full) begin
            id_valid_d = 1'b1;
            id_entry_d = buf_data;
            buf_rd     = 1'b1;
            buf_wr     = deliver;
        end else if (deliver && (!id_valid_q || !stall)) begin
            id_valid_d = 1'b1;
            id_entry_d = resp_entry;
        end else if (deliver) begin
            buf_wr = 1'b1;
        end else if (!stall) begin
            id_valid_d       = 1'b0;
            id_entry_d.instr = NOP_INSTR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            drop_q     <= 1'b0;
            id_valid_q <= 1'b0;
            id_entry_q <= '{pc: '0, instr: NOP_INSTR};
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            drop_q     <= drop_d;
            id_valid_q <= id_valid_d;
            id_entry_q <= id_entry_d;
            count_q    <= count_d;
        end
    end

    fetch_skid_buf u_skid (
        .clk       (clk),
        .rst       (rst),
        .wr_i      (buf_wr),
        .rd_i      (buf_rd),
        .clr_i     (buf_clr),
        .wr_data_i (resp_entry),
        .rd_data_o (buf_data),
        .full_o    (buf_full)
    );

    assign imem_req_valid = (state_q == REQ);
    assign imem_addr      = addr_q;
    assign pc_hold        = !handshake;
    assign id_valid       = id_valid_q;
    assign id_instr       = id_entry_q.instr;
    assign id_pc          = id_entry_q.pc;
    assign id_pc_plus4    = id_entry_q.pc + WORD_SIZE'(4);
    assign fetch_count    = count_q;
    assign dbg_state      = state_q;
    assign dbg_buf_full   = buf_full;

    // Memory may only answer the single outstanding request.
    resp_only_in_wait: assert property (@(posedge clk) disable iff (rst)
        imem_resp_valid |-> (state_q == WAIT));

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed bench for instr_fetch_stage: reset, straight-line fetch, stall/skid,
// flush in WAIT, backpressure with flush, halt and PC wrap.
module tb_instr_fetch_stage;
    import fetch_pkg::*;

    logic         clk = 1'b0;
    logic         rst, halt, stall, flush;
    logic [31:0]  pc_in;
    logic         pc_hold, imem_req_valid, imem_req_ready;
    logic [31:0]  imem_addr;
    logic         imem_resp_valid;
    logic [31:0]  imem_resp_data;
    logic         id_valid;
    logic [31:0]  id_instr, id_pc, id_pc_plus4, fetch_count;
    fetch_state_t dbg_state;
    logic         dbg_buf_full;

    int n_checks = 0;
    int n_errors = 0;

    instr_fetch_stage dut (
        .clk             (clk),
        .rst             (rst),
        .halt            (halt),
        .stall           (stall),
        .flush           (flush),
        .pc_in           (pc_in),
        .pc_hold         (pc_hold),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .id_valid        (id_valid),
        .id_instr        (id_instr),
        .id_pc           (id_pc),
        .id_pc_plus4     (id_pc_plus4),
        .fetch_count     (fetch_count),
        .dbg_state       (dbg_state),
        .dbg_buf_full    (dbg_buf_full)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req();
        int i;
        for (i = 0; i < 8 && !imem_req_valid; i++) tick();
        check("req_seen", {31'd0, imem_req_valid}, 32'd1);
    endtask

    // Wait for a request, check its address, accept it and advance the PC by 4.
    task automatic accept(input logic [31:0] exp_addr);
        wait_req();
        check("req_addr", imem_addr, exp_addr);
        imem_req_ready = 1'b1;
        #1;
        check("hold_on_accept", {31'd0, pc_hold}, 32'd0);
        tick();
        imem_req_ready = 1'b0;
        pc_in = pc_in + 32'd4;
    endtask

    task automatic respond(input logic [31:0] data);
        imem_resp_valid = 1'b1;
        imem_resp_data  = data;
        tick();
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
    endtask

    task automatic check_id(input string tag, input logic [31:0] pc, input logic [31:0] instr);
        check({tag, "_valid"}, {31'd0, id_valid}, 32'd1);
        check({tag, "_pc"}, id_pc, pc);
        check({tag, "_pc4"}, id_pc_plus4, pc + 32'd4);
        check({tag, "_instr"}, id_instr, instr);
    endtask

    initial begin
        rst = 1'b1; halt = 1'b0; stall = 1'b0; flush = 1'b0; pc_in = 32'h0;
        imem_req_ready = 1'b1; imem_resp_valid = 1'b1; imem_resp_data = 32'h1234_5678;

        // Reset with noise on the memory inputs
        tick();
        tick();
        check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("rst_addr", imem_addr, 32'd0);
        check("rst_id_valid", {31'd0, id_valid}, 32'd0);
        check("rst_id_instr", id_instr, 32'd0);
        check("rst_id_pc", id_pc, 32'd0);
        check("rst_count", fetch_count, 32'd0);
        check("rst_state", {30'd0, dbg_state}, 32'd0);
        check("rst_pc_hold", {31'd0, pc_hold}, 32'd1);
        check("rst_buf_full", {31'd0, dbg_buf_full}, 32'd0);
        imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
        rst = 1'b0;

        // Straight-line fetch 0, 4, 8
        accept(32'h0);
        respond(32'hA000_0000);
        check_id("sl0", 32'h0, 32'hA000_0000);
        accept(32'h4);
        respond(32'hA000_0004);
        check_id("sl4", 32'h4, 32'hA000_0004);
        accept(32'h8);
        respond(32'hA000_0008);
        check_id("sl8", 32'h8, 32'hA000_0008);
        halt = 1'b1;
        tick();
        check("sl_count", fetch_count, 32'd3);
        check("sl_drain_valid", {31'd0, id_valid}, 32'd0);
        check("sl_drain_instr", id_instr, NOP_INSTR);
        check("halt_no_req", {31'd0, imem_req_valid}, 32'd0);

        // Stall with a response landing in the skid buffer
        halt = 1'b0;
        pc_in = 32'h10;
        accept(32'h10);
        respond(32'hB000_0010);
        check_id("st10", 32'h10, 32'hB000_0010);
        stall = 1'b1;
        accept(32'h14);
        respond(32'hB000_0014);
        check("st_hold_pc", id_pc, 32'h10);
        check("st_hold_instr", id_instr, 32'hB000_0010);
        check("st_buf_full", {31'd0, dbg_buf_full}, 32'd1);
        tick();
        check("st_no_req1", {31'd0, imem_req_valid}, 32'd0);
        tick();
        check("st_no_req2", {31'd0, imem_req_valid}, 32'd0);
        check("st_count", fetch_count, 32'd3);
        stall = 1'b0;
        halt = 1'b1;
        tick();
        check_id("st14", 32'h14, 32'hB000_0014);
        check("st_buf_empty", {31'd0, dbg_buf_full}, 32'd0);
        tick();
        check("st_count2", fetch_count, 32'd5);

        // Flush while waiting for the response
        halt = 1'b0;
        pc_in = 32'h20;
        accept(32'h20);
        flush = 1'b1;
        pc_in = 32'h100;
        tick();
        flush = 1'b0;
        check("fw_state_wait", {30'd0, dbg_state}, 32'd2);
        respond(32'hDEAD_BEEF);
        check("fw_dropped_valid", {31'd0, id_valid}, 32'd0);
        check("fw_dropped_instr", id_instr, NOP_INSTR);
        accept(32'h100);
        respond(32'hC000_0100);
        check_id("fw100", 32'h100, 32'hC000_0100);
        halt = 1'b1;
        tick();
        check("fw_count", fetch_count, 32'd6);

        // Backpressure for 3 cycles with a flush in the second
        halt = 1'b0;
        wait_req();
        check("bp_addr1", imem_addr, 32'h104);
        check("bp_hold1", {31'd0, pc_hold}, 32'd1);
        tick();
        flush = 1'b1;
        pc_in = 32'h200;
        #1;
        check("bp_addr2", imem_addr, 32'h104);
        check("bp_hold2", {31'd0, pc_hold}, 32'd1);
        tick();
        flush = 1'b0;
        check("bp_addr3", imem_addr, 32'h104);
        check("bp_hold3", {31'd0, pc_hold}, 32'd1);
        check("bp_req3", {31'd0, imem_req_valid}, 32'd1);
        tick();
        accept(32'h104);
        pc_in = 32'h200;
        respond(32'h0BAD_0BAD);
        check("bp_dropped_valid", {31'd0, id_valid}, 32'd0);
        accept(32'h200);
        respond(32'hD000_0200);
        check_id("bp200", 32'h200, 32'hD000_0200);

        // Halt during WAIT, PC wrap
        pc_in = 32'hFFFF_FFFC;
        accept(32'hFFFF_FFFC);
        halt = 1'b1;
        tick();
        check("hw_hold", {31'd0, pc_hold}, 32'd1);
        check("hw_no_req", {31'd0, imem_req_valid}, 32'd0);
        respond(32'hE000_FFFC);
        check_id("hw", 32'hFFFF_FFFC, 32'hE000_FFFC);
        check("hw_wrap_pc4", id_pc_plus4, 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("hw_idle_no_req", {31'd0, imem_req_valid}, 32'd0);
        end
        check("hw_count", fetch_count, 32'd8);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
